// File: rtl/adc_capture_pkg.sv
// Shared types and defaults for the ADC capture controller.
package adc_capture_pkg;

  localparam int unsigned SAMPLE_W      = 8;
  localparam int unsigned DEF_BUF_DEPTH = 32;
  localparam int unsigned DEF_PRE_TRIG  = 16;
  localparam int unsigned DEF_TIMEOUT   = 255;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REQ_HI = 3'd1,
    ST_REQ_LO = 3'd2,
    ST_DONE   = 3'd3,
    ST_ERR    = 3'd4
  } state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/adc_capture_ctrl.sv
// Four-phase ADC initiator with a pre/post-trigger ring buffer and
// chronological readout of the captured window.
module adc_capture_ctrl
  import adc_capture_pkg::*;
#(
  parameter int unsigned BUF_DEPTH = DEF_BUF_DEPTH,
  parameter int unsigned PRE_TRIG  = DEF_PRE_TRIG,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [SAMPLE_W-1:0] threshold,
  output logic                req,
  input  logic                rdy,
  input  logic [SAMPLE_W-1:0] dat,
  output logic                busy,
  output logic                trd,
  output logic                done,
  output logic                err,
  input  logic                rd_en,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                rd_valid
);

  localparam int unsigned AW   = $clog2(BUF_DEPTH);
  localparam int unsigned NW   = $clog2(BUF_DEPTH + 1);
  localparam int unsigned CW   = $clog2(TIMEOUT + 1);
  localparam int unsigned POST = BUF_DEPTH - PRE_TRIG - 1;

  state_t              state, state_nx;
  logic                req_nx;
  logic                rdy_s;
  logic [CW-1:0]       tmo_cnt;
  logic [AW-1:0]       wptr, rd_ptr;
  logic [NW-1:0]       pre_cnt, post_cnt, rd_cnt;
  logic                capture, launch, rd_fire, tmo, complete;
  logic [SAMPLE_W-1:0] mem [BUF_DEPTH];

  sync2 u_rdy_sync (
    .clk (clk),
    .rst (rst),
    .d   (rdy),
    .q   (rdy_s)
  );

  assign tmo      = (tmo_cnt == CW'(TIMEOUT - 1));
  assign complete = trd && (post_cnt == NW'(POST));

  // req only rises with rdy_s low and only falls after rdy_s was seen high;
  // entering REQ_HI from IDLE/ERR waits for a stale rdy to clear first.
  always_comb begin
    state_nx = state;
    req_nx   = req;
    capture  = 1'b0;
    launch   = 1'b0;
    rd_fire  = 1'b0;
    unique case (state)
      ST_IDLE, ST_ERR: begin
        req_nx = 1'b0;
        if (start) begin
          state_nx = ST_REQ_HI;
          launch   = 1'b1;
        end
      end
      ST_REQ_HI: begin
        if (abort) begin
          state_nx = ST_IDLE;
          req_nx   = 1'b0;
        end else if (tmo) begin
          state_nx = ST_ERR;
          req_nx   = 1'b0;
        end else if (req && rdy_s) begin
          capture  = 1'b1;
          req_nx   = 1'b0;
          state_nx = ST_REQ_LO;
        end else if (!req && !rdy_s) begin
          req_nx = 1'b1;
        end
      end
      ST_REQ_LO: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (tmo) begin
          state_nx = ST_ERR;
        end else if (!rdy_s) begin
          if (complete) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_REQ_HI;
            req_nx   = 1'b1;
          end
        end
      end
      ST_DONE: begin
        if (abort) begin
          state_nx = ST_IDLE;
        end else if (rd_en) begin
          rd_fire = 1'b1;
          if (rd_cnt == NW'(BUF_DEPTH - 1)) state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        req_nx   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      req      <= 1'b0;
      tmo_cnt  <= '0;
      wptr     <= '0;
      rd_ptr   <= '0;
      pre_cnt  <= '0;
      post_cnt <= '0;
      rd_cnt   <= '0;
      trd      <= 1'b0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      state    <= state_nx;
      req      <= req_nx;
      rd_valid <= rd_fire;
      tmo_cnt  <= (state_nx != state) ? '0 : tmo_cnt + 1'b1;

      if (launch) begin
        wptr     <= '0;
        pre_cnt  <= '0;
        post_cnt <= '0;
        rd_cnt   <= '0;
        trd      <= 1'b0;
      end

      if (capture) begin
        wptr <= wptr + 1'b1;
        if (!trd) begin
          if (pre_cnt == NW'(PRE_TRIG)) begin
            if (dat > threshold) begin
              trd    <= 1'b1;
              rd_ptr <= wptr - AW'(PRE_TRIG);
            end
          end else begin
            pre_cnt <= pre_cnt + 1'b1;
          end
        end else begin
          post_cnt <= post_cnt + 1'b1;
        end
      end

      if (rd_fire) begin
        rd_data <= mem[rd_ptr];
        rd_ptr  <= rd_ptr + 1'b1;
        rd_cnt  <= rd_cnt + 1'b1;
      end

      if (state_nx == ST_IDLE && state != ST_IDLE) trd <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) mem[wptr] <= dat;
  end

  assign busy = (state == ST_REQ_HI) || (state == ST_REQ_LO);
  assign done = (state == ST_DONE);
  assign err  = (state == ST_ERR);

endmodule
